// File: rtl/rr_arb16_pkg.sv
// rtl/rr_arb16_pkg.sv - shared widths, state encoding and helpers for rr_arb16
package rr_arb16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

    // Index arithmetic is modulo 16, so owner 15 naturally wraps to 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        return i + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arb16_if.sv
// rtl/rr_arb16_if.sv - request/grant bundle between requesters and rr_arb16
interface rr_arb16_if;
    import rr_arb16_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

endinterface

// File: rtl/rr_arb16_prio_enc16.sv
// rtl/rr_arb16_prio_enc16.sv - lowest-index-first 16-to-4 priority encoder
module prio_enc16
    import rr_arb16_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - sixteen-way round-robin arbiter with optional hold timeout
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int MAX_HOLD = 0
) (
    input  logic        clk,
    input  logic        rst,
    rr_arb16_if.slave   bus
);

    localparam int               CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit               TO_EN     = (MAX_HOLD > 0);
    localparam int               LAST_I    = TO_EN ? MAX_HOLD - 1 : 0;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [IDX_W-1:0] idx_m;
    logic [IDX_W-1:0] idx_r;
    logic             valid_m;
    logic             valid_r;
    logic [IDX_W-1:0] winner;
    logic             owner_req;

    // Requesters at or above the pointer get first pick; below it only if nobody above asks.
    assign mask   = {N_REQ{1'b1}} << ptr;
    assign masked = bus.req & mask;

    prio_enc16 u_enc_masked (
        .vec   (masked),
        .idx   (idx_m),
        .valid (valid_m)
    );

    prio_enc16 u_enc_raw (
        .vec   (bus.req),
        .idx   (idx_r),
        .valid (valid_r)
    );

    assign winner    = valid_m ? idx_m : idx_r;
    assign owner_req = bus.req[bus.gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            hold_cnt      <= '0;
            bus.gnt       <= '0;
            bus.gnt_idx   <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_r) begin
                        bus.gnt       <= onehot(winner);
                        bus.gnt_idx   <= winner;
                        bus.gnt_valid <= 1'b1;
                        hold_cnt      <= '0;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    // Release is checked first so a drop on the last allowed cycle is not a timeout.
                    if (!owner_req) begin
                        bus.gnt       <= '0;
                        bus.gnt_idx   <= '0;
                        bus.gnt_valid <= 1'b0;
                        ptr           <= next_ptr(bus.gnt_idx);
                        state         <= IDLE;
                    end else if (TO_EN && hold_cnt == HOLD_LAST) begin
                        bus.gnt       <= '0;
                        bus.gnt_idx   <= '0;
                        bus.gnt_valid <= 1'b0;
                        bus.timeout   <= 1'b1;
                        ptr           <= next_ptr(bus.gnt_idx);
                        state         <= IDLE;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb16.sv
// tb/tb_rr_arb16.sv - self-checking bench for rr_arb16 with three timeout settings
module tb_rr_arb16;
    import rr_arb16_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_arb16_if b0 ();
    rr_arb16_if b4 ();
    rr_arb16_if b3 ();

    rr_arb16 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    rr_arb16 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    rr_arb16 #(.MAX_HOLD(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    wire [21:0] o0 = {b0.gnt, b0.gnt_idx, b0.gnt_valid, b0.timeout};
    wire [21:0] o4 = {b4.gnt, b4.gnt_idx, b4.gnt_valid, b4.timeout};
    wire [21:0] o3 = {b3.gnt, b3.gnt_idx, b3.gnt_valid, b3.timeout};

    // Reference: owner (-1 when idle), search start, cycles of grant already shown, timeout pulse.
    typedef struct {
        int owner;
        int ptr;
        int held;
        bit to;
    } model_t;

    typedef struct {
        logic [15:0] req;
        logic        rst;
        logic [15:0] gnt;
        logic [3:0]  idx;
        logic        v;
        logic        to;
    } vec_t;

    model_t m0, m4, m3;
    int cmp_cnt = 0;
    int err_cnt = 0;

    function automatic model_t mnext(input model_t m, input logic [15:0] r,
                                     input logic rs, input int maxh);
        model_t n;
        bit found;
        n = m;
        n.to = 1'b0;
        if (rs) begin
            n.owner = -1;
            n.ptr   = 0;
            n.held  = 0;
        end else if (m.owner < 0) begin
            found = 1'b0;
            for (int i = 0; i < 16; i++) begin
                int j;
                j = (m.ptr + i) % 16;
                if (!found && r[j]) begin
                    found   = 1'b1;
                    n.owner = j;
                    n.held  = 1;
                end
            end
        end else if (!r[m.owner]) begin
            n.owner = -1;
            n.ptr   = (m.owner + 1) % 16;
        end else if (maxh > 0 && m.held >= maxh) begin
            n.owner = -1;
            n.ptr   = (m.owner + 1) % 16;
            n.to    = 1'b1;
        end else begin
            n.held = m.held + 1;
        end
        return n;
    endfunction

    function automatic logic [21:0] mexp(input model_t m);
        logic [15:0] g;
        logic [3:0]  ix;
        g  = '0;
        ix = '0;
        if (m.owner >= 0) begin
            g       = '0;
            g[m.owner] = 1'b1;
            ix      = 4'(m.owner);
        end
        return {g, ix, (m.owner >= 0), m.to};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
                     name, $time, act[21:6], act[5:2], act[1], act[0],
                     exp[21:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic cycle(input logic [15:0] r, input logic rs);
        @(negedge clk);
        b0.req = r;
        b4.req = r;
        b3.req = r;
        rst    = rs;
        @(posedge clk);
        m0 = mnext(m0, r, rs, 0);
        m4 = mnext(m4, r, rs, 4);
        m3 = mnext(m3, r, rs, 3);
        #1;
        check("model_hold0", o0, mexp(m0));
        check("model_hold4", o4, mexp(m4));
        check("model_hold3", o3, mexp(m3));
    endtask

    vec_t vt [22];

    initial begin
        logic [15:0] r;
        logic [15:0] g;
        logic        rs;

        b0.req = '0;
        b4.req = '0;
        b3.req = '0;
        m0 = '{-1, 0, 0, 1'b0};
        m4 = '{-1, 0, 0, 1'b0};
        m3 = '{-1, 0, 0, 1'b0};

        vt[0]  = '{16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vt[1]  = '{16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        vt[2]  = '{16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        vt[3]  = '{16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        vt[4]  = '{16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        vt[5]  = '{16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        vt[6]  = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vt[7]  = '{16'h0021, 1'b0, 16'h0020, 4'd5,  1'b1, 1'b0};
        vt[8]  = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vt[9]  = '{16'h2000, 1'b0, 16'h2000, 4'd13, 1'b1, 1'b0};
        vt[10] = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vt[11] = '{16'h0003, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        vt[12] = '{16'h0002, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vt[13] = '{16'h0002, 1'b0, 16'h0002, 4'd1,  1'b1, 1'b0};
        vt[14] = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vt[15] = '{16'h0080, 1'b0, 16'h0080, 4'd7,  1'b1, 1'b0};
        vt[16] = '{16'h0081, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vt[17] = '{16'h0081, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        vt[18] = '{16'h0081, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        vt[19] = '{16'h0080, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vt[20] = '{16'h0080, 1'b0, 16'h0080, 4'd7,  1'b1, 1'b0};
        vt[21] = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};

        for (int i = 0; i < 22; i++) begin
            cycle(vt[i].req, vt[i].rst);
            check($sformatf("vec%0d", i), o0, {vt[i].gnt, vt[i].idx, vt[i].v, vt[i].to});
        end

        // Full contention: order 0..15 then 0 again, one idle cycle between grants.
        cycle(16'h0000, 1'b1);
        for (int i = 0; i < 17; i++) begin
            g = '0;
            g[i % 16] = 1'b1;
            cycle(16'hFFFF, 1'b0);
            check("contend_grant", o0, {g, 4'(i % 16), 1'b1, 1'b0});
            cycle(16'hFFFF & ~g, 1'b0);
            check("contend_idle", o0, 22'h0);
        end

        // Timeout with MAX_HOLD=4.
        cycle(16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(16'h0104, 1'b0);
            check("to_hold", o4, {16'h0004, 4'd2, 1'b1, 1'b0});
        end
        cycle(16'h0104, 1'b0);
        check("to_pulse", o4, {16'h0000, 4'd0, 1'b0, 1'b1});
        cycle(16'h0104, 1'b0);
        check("to_next", o4, {16'h0100, 4'd8, 1'b1, 1'b0});
        cycle(16'h0000, 1'b0);
        check("to_release", o4, 22'h0);

        // Release and timeout coincide with MAX_HOLD=3: release wins.
        cycle(16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(16'h0010, 1'b0);
            check("tie_hold", o3, {16'h0010, 4'd4, 1'b1, 1'b0});
        end
        cycle(16'h0000, 1'b0);
        check("tie_release", o3, 22'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(16'h0010, 1'b0);
        end
        cycle(16'h0010, 1'b0);
        check("tie_ref_timeout", o3, {16'h0000, 4'd0, 1'b0, 1'b1});
        cycle(16'h0000, 1'b0);

        // Random: sparse bit flips keep requests alive for several cycles.
        r = '0;
        for (int n = 0; n < 3000; n++) begin
            r  = r ^ 16'($urandom & $urandom & $urandom);
            rs = ($urandom_range(0, 199) == 0);
            cycle(r, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
